uart_debug_unit: RTL
====================

// Module: uart_debug_unit
// PURPOSE
//  Command sequencer between top_uart FIFOs and the pipeline. Pops command bytes from the RX FIFO.
//  Executes them: load program into instruction memory, run, step, dump state.
//  Answers over the TX FIFO. Sole master of the pipeline enable/reset during debug.
// PARAMETERS
//  DATA_WIDTH       8   UART byte width
//  WORD_WIDTH       32  instruction / register / PC width (multiple of DATA_WIDTH)
//  IMEM_ADDR_WIDTH  8   instruction memory word-address width
//  NREG             32  registers sent in a dump
//  REG_ADDR_WIDTH   5   register file address width
// PORTS
//  i_clock        in   1           system clock
//  i_reset        in   1           synchronous, active-high reset
//  i_rx_data      in   DATA_WIDTH  RX FIFO head (first-word-fall-through, valid when !i_rx_empty)
//  i_rx_empty     in   1           RX FIFO empty
//  o_rx_read      out  1           pop RX FIFO head this cycle
//  o_tx_data      out  DATA_WIDTH  byte to TX FIFO
//  i_tx_full      in   1           TX FIFO full
//  o_tx_write     out  1           push o_tx_data this cycle
//  o_imem_we      out  1           instruction memory write strobe
//  o_imem_addr    out  IMEM_ADDR_WIDTH  instruction word address
//  o_imem_data    out  WORD_WIDTH  instruction word
//  o_pipe_enable  out  1           pipeline clock enable
//  o_pipe_reset   out  1           pipeline reset
//  i_halt         in   1           pipeline executed HALT
//  i_pc           in   WORD_WIDTH  current PC
//  o_reg_addr     out  REG_ADDR_WIDTH  register file read address (async read)
//  i_reg_data     in   WORD_WIDTH  register read data
//  o_busy         out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte/word counters and partial word cleared; in-flight op abandoned.
//  Handshakes:
//   - o_rx_read high only when !i_rx_empty and state consumes a byte; the byte is consumed that cycle.
//   - o_tx_write high only when !i_tx_full; the byte is held stable until accepted.
//  IDLE: pops one byte per cycle while !i_rx_empty. Commands:
//   'L'(0x4C) load, 'R'(0x52) run, 'S'(0x53) step, 'D'(0x44) dump.
//   Any other byte -> send NAK 0x15, back to IDLE.
//  Non-IDLE states never pop the RX FIFO, except LOAD_CNT/LOAD_BYTE. Queued commands wait.
//  LOAD: o_pipe_reset held high in all load states.
//   - LOAD_CNT pops N, the instruction count. N=0 -> ACK 0x06.
//   - LOAD_BYTE pops 4 bytes per word, MSB first. After the 4th byte: o_imem_we=1 for exactly 1 cycle,
//     addr = word index 0..N-1 (wraps mod 2^IMEM_ADDR_WIDTH).
//   - After word N-1 -> send ACK 0x06 -> IDLE.
//  RUN: o_pipe_enable=1 from the cycle after the 'R' pop.
//   - Cleared on the cycle after i_halt is sampled high, then DUMP.
//   - i_halt already high at 'R' -> zero enable cycles, straight to DUMP.
//  STEP: o_pipe_enable=1 for exactly 1 cycle (0 cycles if i_halt high), then DUMP.
//  DUMP ('D', or end of RUN/STEP):
//   - Sends 4+4*NREG bytes: PC, then reg 0..NREG-1, each word MSB first.
//   - Word captured into a shift register when its first byte is staged.
//   - o_reg_addr is stable while that word's 4 bytes drain.
//   - TX full stalls without loss or duplication. Then IDLE.
//  States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_LOAD, DUMP_SEND, SEND_RESP.
//  Registered outputs. o_imem_data/o_imem_addr valid while o_imem_we high.
// STRUCTURE
//  debug_defs.vh: command codes, ACK/NAK, state encodings, bytes-per-word constant.
//  Sub-module word_serializer:
//   - loads WORD_WIDTH, emits DATA_WIDTH bytes MSB first under tx_full backpressure.
//   - Signals done after the last byte is accepted.
// TESTING
//  Load: 'L',0x02,11 22 33 44,AA BB CC DD ->
//   we@addr0=0x11223344, we@addr1=0xAABBCCDD, one ACK 0x06, pipe_reset high throughout.
//  Unknown 0x7A then 'D' -> TX 0x15, then 132 bytes: PC first, then r0..r31 MSB first.
//  'R', i_halt rises after 10 enable cycles -> exactly 10 enable cycles, then full dump.
//  'S' twice -> two single-cycle enable pulses, two dumps. 'S' with i_halt=1 -> no pulse, dump only.
//  i_tx_full toggled randomly during dump -> byte stream identical to the unstalled run.
//  Reset mid-LOAD after 6 bytes, then 'D' -> no further imem writes, clean dump, no ACK from aborted load.

Source files
------------

// File: rtl/uart_debug_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_debug_unit_pkg
//  Description : Command codes, response codes, FSM state encoding and a
//                word/byte sizing helper shared by the UART debug unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_debug_unit_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'

  // Response bytes
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_CNT   = 4'd1,
    LOAD_BYTE  = 4'd2,
    LOAD_WRITE = 4'd3,
    RUN        = 4'd4,
    STEP       = 4'd5,
    DUMP_LOAD  = 4'd6,
    DUMP_SEND  = 4'd7,
    SEND_RESP  = 4'd8
  } dbg_state_t;

  // Number of UART bytes that make up one machine word
  function automatic int bytes_per_word(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_debug_unit_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_unit_word_serializer
//  Description : Captures one word and emits it byte by byte, MSB first,
//                holding each byte until the TX FIFO has room. Pulses done
//                the cycle after the last byte is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_debug_unit_word_serializer
  import uart_debug_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_write,
  output logic                  done
);

  localparam int BPW   = bytes_per_word(WORD_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(BPW + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BPW);

  logic [WORD_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      remaining;

  // Head byte is always the top slice; it only moves once accepted
  always_comb begin
    tx_data  = shreg[WORD_WIDTH-1 -: DATA_WIDTH];
    tx_write = (remaining != '0) && !tx_full;
  end

  // Capture on load, shift out one byte per accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg     <= word;
        remaining <= CNT_FULL;
      end else if (tx_write) begin
        shreg     <= shreg << DATA_WIDTH;
        remaining <= remaining - CNT_ONE;
        if (remaining == CNT_ONE) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_debug_unit.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_unit
//  Description : Command sequencer between the UART FIFOs and the pipeline.
//                Loads programs, runs, single-steps and dumps PC + registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_debug_unit
  import uart_debug_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int WORD_WIDTH      = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int NREG            = 32,
  parameter int REG_ADDR_WIDTH  = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [DATA_WIDTH-1:0]      i_rx_data,
  input  logic                       i_rx_empty,
  output logic                       o_rx_read,
  output logic [DATA_WIDTH-1:0]      o_tx_data,
  input  logic                       i_tx_full,
  output logic                       o_tx_write,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [WORD_WIDTH-1:0]      o_imem_data,
  output logic                       o_pipe_enable,
  output logic                       o_pipe_reset,
  input  logic                       i_halt,
  input  logic [WORD_WIDTH-1:0]      i_pc,
  output logic [REG_ADDR_WIDTH-1:0]  o_reg_addr,
  input  logic [WORD_WIDTH-1:0]      i_reg_data,
  output logic                       o_busy
);

  localparam int BPW    = bytes_per_word(WORD_WIDTH, DATA_WIDTH);
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DIDX_W = REG_ADDR_WIDTH + 1;

  localparam logic [BCNT_W-1:0]          LAST_BYTE = BCNT_W'(BPW - 1);
  localparam logic [BCNT_W-1:0]          BCNT_ONE  = BCNT_W'(1);
  localparam logic [DATA_WIDTH-1:0]      WCNT_ONE  = DATA_WIDTH'(1);
  localparam logic [IMEM_ADDR_WIDTH-1:0] ADDR_ONE  = IMEM_ADDR_WIDTH'(1);
  localparam logic [DIDX_W-1:0]          DIDX_ONE  = DIDX_W'(1);
  localparam logic [DIDX_W-1:0]          LAST_DIDX = DIDX_W'(NREG);

  dbg_state_t state, next_state;

  logic [WORD_WIDTH-DATA_WIDTH-1:0] partial;    // bytes of the word being loaded
  logic [WORD_WIDTH-1:0]            assembled;  // partial word plus RX head byte
  logic [BCNT_W-1:0]                byte_cnt;
  logic [DATA_WIDTH-1:0]            n_words;
  logic [DATA_WIDTH-1:0]            word_cnt;
  logic [IMEM_ADDR_WIDTH-1:0]       load_addr;
  logic [DATA_WIDTH-1:0]            resp;
  logic [DIDX_W-1:0]                dump_idx;   // 0 = PC, k = register k-1

  logic                  ser_load;
  logic                  ser_write;
  logic                  ser_done;
  logic [DATA_WIDTH-1:0] ser_data;
  logic [WORD_WIDTH-1:0] dump_word;

  assign assembled = {partial, i_rx_data};
  assign dump_word = (dump_idx == '0) ? i_pc : i_reg_data;

  uart_debug_unit_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_word_serializer (
    .clk      (i_clock),
    .rst      (i_reset),
    .load     (ser_load),
    .word     (dump_word),
    .tx_full  (i_tx_full),
    .tx_data  (ser_data),
    .tx_write (ser_write),
    .done     (ser_done)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, FIFO handshakes and TX byte source selection
  always_comb begin
    next_state = state;
    o_rx_read  = 1'b0;
    ser_load   = 1'b0;
    o_tx_data  = ser_data;
    o_tx_write = 1'b0;
    if (!i_reset) begin
      case (state)
        IDLE: begin
          if (!i_rx_empty) begin
            o_rx_read = 1'b1;
            if (i_rx_data == DATA_WIDTH'(CMD_LOAD)) begin
              next_state = LOAD_CNT;
            end else if (i_rx_data == DATA_WIDTH'(CMD_RUN)) begin
              next_state = i_halt ? DUMP_LOAD : RUN;
            end else if (i_rx_data == DATA_WIDTH'(CMD_STEP)) begin
              next_state = i_halt ? DUMP_LOAD : STEP;
            end else if (i_rx_data == DATA_WIDTH'(CMD_DUMP)) begin
              next_state = DUMP_LOAD;
            end else begin
              next_state = SEND_RESP;
            end
          end
        end
        LOAD_CNT: begin
          if (!i_rx_empty) begin
            o_rx_read  = 1'b1;
            next_state = (i_rx_data == '0) ? SEND_RESP : LOAD_BYTE;
          end
        end
        LOAD_BYTE: begin
          if (!i_rx_empty) begin
            o_rx_read = 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              next_state = LOAD_WRITE;
            end
          end
        end
        LOAD_WRITE: begin
          next_state = (word_cnt + WCNT_ONE == n_words) ? SEND_RESP : LOAD_BYTE;
        end
        RUN: begin
          if (i_halt) begin
            next_state = DUMP_LOAD;
          end
        end
        STEP: begin
          next_state = DUMP_LOAD;
        end
        DUMP_LOAD: begin
          ser_load   = 1'b1;
          next_state = DUMP_SEND;
        end
        DUMP_SEND: begin
          o_tx_write = ser_write;
          if (ser_done) begin
            next_state = (dump_idx == LAST_DIDX) ? IDLE : DUMP_LOAD;
          end
        end
        SEND_RESP: begin
          o_tx_data  = resp;
          o_tx_write = !i_tx_full;
          if (!i_tx_full) begin
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Load/dump datapath and registered pipeline/imem/status outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_imem_we     <= 1'b0;
      o_imem_addr   <= '0;
      o_imem_data   <= '0;
      o_pipe_enable <= 1'b0;
      o_pipe_reset  <= 1'b0;
      o_reg_addr    <= '0;
      o_busy        <= 1'b0;
      partial       <= '0;
      byte_cnt      <= '0;
      n_words       <= '0;
      word_cnt      <= '0;
      load_addr     <= '0;
      resp          <= '0;
      dump_idx      <= '0;
    end else begin
      o_imem_we     <= 1'b0;
      o_pipe_reset  <= (next_state == LOAD_CNT) || (next_state == LOAD_BYTE) ||
                       (next_state == LOAD_WRITE);
      o_pipe_enable <= (next_state == RUN) || ((state == IDLE) && (next_state == STEP));
      o_busy        <= (next_state != IDLE);
      case (state)
        IDLE: begin
          byte_cnt   <= '0;
          word_cnt   <= '0;
          load_addr  <= '0;
          dump_idx   <= '0;
          o_reg_addr <= '0;
          resp       <= DATA_WIDTH'(RESP_NAK);
        end
        LOAD_CNT: begin
          if (o_rx_read) begin
            n_words <= i_rx_data;
            resp    <= DATA_WIDTH'(RESP_ACK);
          end
        end
        LOAD_BYTE: begin
          if (o_rx_read) begin
            partial <= assembled[WORD_WIDTH-DATA_WIDTH-1:0];
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt    <= '0;
              o_imem_we   <= 1'b1;
              o_imem_addr <= load_addr;
              o_imem_data <= assembled;
            end else begin
              byte_cnt <= byte_cnt + BCNT_ONE;
            end
          end
        end
        LOAD_WRITE: begin
          word_cnt  <= word_cnt + WCNT_ONE;
          load_addr <= load_addr + ADDR_ONE;
        end
        DUMP_SEND: begin
          // Advance the register address only between words so it stays put while a word drains
          if (ser_done && (next_state == DUMP_LOAD)) begin
            o_reg_addr <= dump_idx[REG_ADDR_WIDTH-1:0];
            dump_idx   <= dump_idx + DIDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
